// File: rtl/mux2_arb.sv
// Two-requester round-robin arbiter feeding a registered 2:1 mux with a one-beat output stage.
// Optional sticky grant locking is enabled by defining MUX2_ARB_LOCK_EN.
module mux2_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             d0_valid,
  input  logic [WIDTH-1:0] d0,
  output logic             d0_ready,
  input  logic             d1_valid,
  input  logic [WIDTH-1:0] d1,
  output logic             d1_ready,
`ifdef MUX2_ARB_LOCK_EN
  input  logic             d0_lock,
  input  logic             d1_lock,
`endif
  output logic             y_valid,
  output logic [WIDTH-1:0] y,
  output logic             y_sel,
  input  logic             y_ready
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic             y_sel_reg, y_sel_next;
  logic             last_reg, last_next;

  logic [1:0]       req;
  logic [1:0]       ready_vec;
  logic [WIDTH-1:0] mux_data;
  logic             load;
  logic             grant;
  logic             grant_valid;
  logic             accept;

`ifdef MUX2_ARB_LOCK_EN
  logic lock_reg, lock_next;
  logic lock_owner_reg, lock_owner_next;

  // While locked, the non-owner's request is masked so it can never be granted.
  assign req[0] = d0_valid & ~(lock_reg &  lock_owner_reg);
  assign req[1] = d1_valid & ~(lock_reg & ~lock_owner_reg);
`else
  assign req = {d1_valid, d0_valid};
`endif

  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    if (req[0] && req[1]) begin
      grant = ~last_reg;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

  assign load   = (state_reg == EMPTY) | y_ready;
  assign accept = load & grant_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = reset_n & load & req[gi] & (grant == 1'(gi));
    end
    for (gi = 0; gi < WIDTH; gi++) begin : g_mux
      assign mux_data[gi] = grant ? d1[gi] : d0[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    y_sel_next = y_sel_reg;
    last_next  = last_reg;
    if (accept) begin
      state_next = FULL;
      y_next     = mux_data;
      y_sel_next = grant;
      last_next  = grant;
    end else if ((state_reg == FULL) && y_ready) begin
      state_next = EMPTY;
    end
  end

`ifdef MUX2_ARB_LOCK_EN
  // A locked owner releases by sending a beat with its lock bit low.
  always_comb begin
    lock_next       = lock_reg;
    lock_owner_next = lock_owner_reg;
    if (accept) begin
      lock_next       = grant ? d1_lock : d0_lock;
      lock_owner_next = grant;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_reg       <= 1'b0;
      lock_owner_reg <= 1'b0;
    end else begin
      lock_reg       <= lock_next;
      lock_owner_reg <= lock_owner_next;
    end
  end
`endif

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
      y_reg     <= '0;
      y_sel_reg <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      y_sel_reg <= y_sel_next;
      last_reg  <= last_next;
    end
  end

  assign d0_ready = ready_vec[0];
  assign d1_ready = ready_vec[1];
  assign y_valid  = (state_reg == FULL);
  assign y        = y_reg;
  assign y_sel    = y_sel_reg;

endmodule

// File: tb/tb_mux2_arb.sv
// Directed vector bench for mux2_arb: table of single-cycle transactions plus reset and lock sequences.
module tb_mux2_arb;

  logic        clk;
  logic        reset_n;
  logic        d0_valid;
  logic [15:0] d0;
  logic        d0_ready;
  logic        d1_valid;
  logic [15:0] d1;
  logic        d1_ready;
  logic        y_valid;
  logic [15:0] y;
  logic        y_sel;
  logic        y_ready;
`ifdef MUX2_ARB_LOCK_EN
  logic        d0_lock;
  logic        d1_lock;
`endif

  int total;
  int passed;

  mux2_arb #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d0_valid (d0_valid),
    .d0       (d0),
    .d0_ready (d0_ready),
    .d1_valid (d1_valid),
    .d1       (d1),
    .d1_ready (d1_ready),
`ifdef MUX2_ARB_LOCK_EN
    .d0_lock  (d0_lock),
    .d1_lock  (d1_lock),
`endif
    .y_valid  (y_valid),
    .y        (y),
    .y_sel    (y_sel),
    .y_ready  (y_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        d0v;
    logic [15:0] d0d;
    logic        d1v;
    logic [15:0] d1d;
    logic        yr;
    logic        xr0;
    logic        xr1;
    logic        xyv;
    logic [15:0] xy;
    logic        xsel;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Called at a negedge: drive, check readys, cross the posedge, check the output stage.
  task automatic step(input string nm, input vec_t v);
    d0_valid = v.d0v;
    d0       = v.d0d;
    d1_valid = v.d1v;
    d1       = v.d1d;
    y_ready  = v.yr;
    #1;
    check({nm, ".d0_ready"}, 32'(d0_ready), 32'(v.xr0));
    check({nm, ".d1_ready"}, 32'(d1_ready), 32'(v.xr1));
    @(posedge clk);
    #1;
    check({nm, ".y_valid"}, 32'(y_valid), 32'(v.xyv));
    check({nm, ".y"},       32'(y),       32'(v.xy));
    check({nm, ".y_sel"},   32'(y_sel),   32'(v.xsel));
    $display("%s: d0v=%0b d1v=%0b yr=%0b -> rdy=%0b%0b y_valid=%0b y=%h y_sel=%0b",
             nm, v.d0v, v.d1v, v.yr, d1_ready, d0_ready, y_valid, y, y_sel);
    @(negedge clk);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    //           d0v d0        d1v d1        yr  r0 r1 yv  y         sel
    vecs[0]  = '{1, 16'hBEEF, 0, 16'h0000, 1,  1, 0, 1, 16'hBEEF, 0};
    vecs[1]  = '{1, 16'hBEEF, 1, 16'hDEAD, 1,  0, 1, 1, 16'hDEAD, 1};
    vecs[2]  = '{1, 16'hBEEF, 1, 16'hDEAD, 1,  1, 0, 1, 16'hBEEF, 0};
    vecs[3]  = '{1, 16'hBEEF, 1, 16'hDEAD, 1,  0, 1, 1, 16'hDEAD, 1};
    vecs[4]  = '{1, 16'hBEEF, 1, 16'hDEAD, 1,  1, 0, 1, 16'hBEEF, 0};
    vecs[5]  = '{1, 16'hBEEF, 1, 16'hDEAD, 1,  0, 1, 1, 16'hDEAD, 1};
    vecs[6]  = '{1, 16'hBEEF, 0, 16'h0000, 0,  0, 0, 1, 16'hDEAD, 1};
    vecs[7]  = '{1, 16'hBEEF, 0, 16'h0000, 0,  0, 0, 1, 16'hDEAD, 1};
    vecs[8]  = '{1, 16'hBEEF, 0, 16'h0000, 0,  0, 0, 1, 16'hDEAD, 1};
    vecs[9]  = '{1, 16'hBEEF, 0, 16'h0000, 1,  1, 0, 1, 16'hBEEF, 0};
    vecs[10] = '{0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 16'hBEEF, 0};
    vecs[11] = '{0, 16'h0000, 0, 16'h0000, 0,  0, 0, 0, 16'hBEEF, 0};
    vecs[12] = '{0, 16'h0000, 1, 16'h1234, 0,  0, 1, 1, 16'h1234, 1};
    vecs[13] = '{0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 16'h1234, 1};
    vecs[14] = '{0, 16'h0000, 1, 16'hABCD, 1,  0, 1, 1, 16'hABCD, 1};
    vecs[15] = '{1, 16'hBEEF, 1, 16'hDEAD, 1,  1, 0, 1, 16'hBEEF, 0};
    vecs[16] = '{1, 16'h1111, 0, 16'h0000, 0,  0, 0, 1, 16'hBEEF, 0};
    vecs[17] = '{0, 16'h0000, 0, 16'h0000, 1,  0, 0, 0, 16'hBEEF, 0};
    vecs[18] = '{1, 16'h2222, 1, 16'h3333, 1,  0, 1, 1, 16'h3333, 1};

    reset_n  = 1'b1;
    d0_valid = 1'b1;
    d0       = 16'hBEEF;
    d1_valid = 1'b1;
    d1       = 16'hDEAD;
    y_ready  = 1'b1;
`ifdef MUX2_ARB_LOCK_EN
    d0_lock  = 1'b0;
    d1_lock  = 1'b0;
`endif
    #1 reset_n = 1'b0;
    #1;
    check("rst.d0_ready", 32'(d0_ready), 32'd0);
    check("rst.d1_ready", 32'(d1_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.y_valid", 32'(y_valid), 32'd0);
    check("rst.y",       32'(y),       32'd0);
    check("rst.y_sel",   32'(y_sel),   32'd0);
    $display("reset: y_valid=%0b y=%h y_sel=%0b", y_valid, y, y_sel);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset while FULL, released before the next edge; tie must go to d0.
    d0_valid = 1'b1;
    d0       = 16'hBEEF;
    d1_valid = 1'b1;
    d1       = 16'hDEAD;
    y_ready  = 1'b1;
    reset_n  = 1'b0;
    #1;
    check("midrst.y_valid",  32'(y_valid),  32'd0);
    check("midrst.y",        32'(y),        32'd0);
    check("midrst.d0_ready", 32'(d0_ready), 32'd0);
    check("midrst.d1_ready", 32'(d1_ready), 32'd0);
    $display("midrst: y_valid=%0b y=%h", y_valid, y);
    #1 reset_n = 1'b1;
    #1;
    check("postrst.d0_ready", 32'(d0_ready), 32'd1);
    check("postrst.d1_ready", 32'(d1_ready), 32'd0);
    @(posedge clk);
    #1;
    check("postrst.y",     32'(y),     32'hBEEF);
    check("postrst.y_sel", 32'(y_sel), 32'd0);
    $display("postrst: y_valid=%0b y=%h y_sel=%0b", y_valid, y, y_sel);
    @(negedge clk);

`ifdef MUX2_ARB_LOCK_EN
    d1_lock = 1'b1;
    step("lock1", '{1, 16'hBEEF, 1, 16'hA001, 1, 0, 1, 1, 16'hA001, 1});
    step("lock2", '{1, 16'hBEEF, 1, 16'hA002, 1, 0, 1, 1, 16'hA002, 1});
    d1_lock = 1'b0;
    step("lock3", '{1, 16'hBEEF, 1, 16'hA003, 1, 0, 1, 1, 16'hA003, 1});
    step("lock4", '{1, 16'hBEEF, 1, 16'hA004, 1, 1, 0, 1, 16'hBEEF, 0});
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux2_arb.md
MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001: Parameter WIDTH, default 16, data width of both requesters and the output.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: reset_n  input  1  asynchronous, active-low reset.
REQ-004: d0_valid  input  1  requester 0 has a beat on d0.
REQ-005: d0  input  WIDTH  requester 0 data.
REQ-006: d0_ready  output  1  requester 0 beat accepted this cycle when d0_valid is high.
REQ-007: d1_valid, d1, d1_ready: same widths and meanings for requester 1.
REQ-008: y_valid  output  1  output register holds a beat.
REQ-009: y  output  WIDTH  registered mux2 result.
REQ-010: y_sel  output  1  source of the beat in y: 0 = d0, 1 = d1.
REQ-011: y_ready  input  1  consumer accepts y when y_valid is high.

Function
REQ-012: Datapath SHALL be a 2:1 mux (select s = grant) feeding a single output register.
REQ-013: State machine SHALL have two states: EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-014: load = (state==EMPTY) | y_ready; a beat is accepted only when load is high.
REQ-015: Arbitration, evaluated combinationally each cycle: only d0_valid -> grant 0; only d1_valid -> grant 1; both -> grant = ~last; neither -> no grant.
REQ-016: dX_ready SHALL equal load & (grant==X) & dX_valid; at most one ready high per cycle.
REQ-017: On an accepted beat: y <= granted data, y_sel <= grant, last <= grant, state <= FULL; latency 1 cycle input-to-y_valid.
REQ-018: FULL with y_ready=1 and no request: state <= EMPTY, y and y_sel hold their values.
REQ-019: FULL with y_ready=1 and a request: accept new beat the same cycle (back-to-back, 100% throughput).
REQ-020: FULL with y_ready=0: y, y_sel, y_valid, last held; both readys low.
REQ-021: last SHALL update only on accepted beats, never on idle cycles.
REQ-022: Continuous simultaneous requests SHALL alternate grants 0,1,0,1...
REQ-023: y_ready SHALL be ignored in EMPTY.
REQ-024: Valid may deassert without ready; no beat is lost or duplicated, and no grant is stored.

Reset
REQ-025: reset_n low SHALL immediately force state=EMPTY, y_valid=0, y=0, y_sel=0, last=1 (requester 0 wins the first tie).
REQ-026: Reset mid-transfer SHALL discard the held beat; d0_ready and d1_ready SHALL be 0 while reset_n is low.
REQ-027: First accept possible on the first rising edge after reset_n deasserts.

Configuration
REQ-028: Macro MUX2_ARB_LOCK_EN SHALL add inputs d0_lock, d1_lock (1 bit each).
REQ-029: With MUX2_ARB_LOCK_EN: a beat accepted with dX_lock=1 sets a lock; while locked, grant is forced to X and the other requester's ready is 0; lock clears on an accepted beat from X with dX_lock=0; reset clears the lock.
REQ-030: Without MUX2_ARB_LOCK_EN: lock ports absent; pure round-robin per REQ-015.

Verification
REQ-031: Reset, d0=16'hBEEF d0_valid=1, d1 idle, y_ready=1 -> next cycle y=16'hBEEF, y_sel=0, y_valid=1.
REQ-032: Both valid every cycle (d0=16'hBEEF, d1=16'hDEAD), y_ready=1 -> y sequence BEEF, DEAD, BEEF, DEAD, one per cycle.
REQ-033: FULL with y=16'hDEAD, y_ready=0 for 3 cycles, d0 valid -> y holds DEAD, d0_ready=0; y_ready=1 -> BEEF loaded next cycle.
REQ-034: reset_n pulsed low mid-cycle while FULL -> y_valid=0, y=0 immediately, without a clock edge; after release, a tie grants d0.
REQ-035: d1 accepted, then idle, then d1=16'hABCD alone -> y=ABCD, y_sel=1; then a tie -> grant 0.
REQ-036: (MUX2_ARB_LOCK_EN) d1_lock=1 for 2 beats, d0 valid throughout -> d1 beats exclusively until a d1 beat with lock=0, then d0 granted.
